// File: rtl/pio_pkg.sv
// Shared definitions for the PIO pin-read interrupt detect path.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
//
// Contents: default data width, minimum synchroniser depth, the edge-select
// encoding used by the register map and the bench, and a helper that sizes
// the post-reset prime window.
package pio_pkg;

    localparam int PIO_DATA_WIDTH_DEFAULT = 32;
    localparam int PIO_SYNC_STAGES_MIN    = 2;

    typedef enum logic [1:0] {
        EDGE_NONE = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } pio_edge_t;

    // Cycles after reset release during which edge events are suppressed:
    // long enough for the sync chain (and any filter) to fill with real pin
    // levels plus one cycle for the prev register to catch up.
    function automatic int pio_prime_cycles(input int sync_stages, input int filter_cycles);
        return sync_stages + 1 + filter_cycles;
    endfunction

endpackage

// File: rtl/pio_sync_bit.sv
// Single-bit pin synchroniser with optional debounce filter.
// Latency: SYNC_STAGES cycles, plus DEBOUNCE_CYCLES when the filter is built.
// Backpressure: none; samples every cycle.
//
// Optional feature macro: PIO_IRQ_DEBOUNCE_EN (adds the debounce filter).
// Ports:
//   clock    - sole clock
//   reset    - synchronous, active-high; clears chain, filter and counter
//   pin_in   - raw asynchronous pin level
//   sync_out - synchronised (optionally debounced) level
module pio_sync_bit
    import pio_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic pin_in,
    output logic sync_out
);

    // Elaboration-time guard on the legal parameter ranges.
    if (SYNC_STAGES < PIO_SYNC_STAGES_MIN || SYNC_STAGES > 4) begin : g_bad_sync
        $error("pio_sync_bit: SYNC_STAGES must be 2..4");
    end
    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255) begin : g_bad_db
        $error("pio_sync_bit: DEBOUNCE_CYCLES must be 2..255");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pin_in};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

`ifdef PIO_IRQ_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          raw;
    logic          filt_q;
    logic          filt_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign raw = sync_q[SYNC_STAGES-1];

    // The counter tracks how many consecutive cycles the raw level has
    // disagreed with the filtered level; any agreement restarts it. The
    // filtered level only follows once the disagreement has lasted the full
    // window, so the flip happens on the cycle the count would reach
    // DEBOUNCE_CYCLES.
    always_comb begin
        cnt_d  = '0;
        filt_d = filt_q;
        if (raw != filt_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                filt_d = raw;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            filt_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign sync_out = filt_q;
`else
    assign sync_out = sync_q[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/pio_irq_detect.sv
// Pin edge detector with sticky pending bits and two masked interrupt lines.
// Latency: pin->sync_data SYNC_STAGES, ->pending +1, ->irq +1 (filter adds DEBOUNCE_CYCLES).
// Backpressure: none; pending is sticky until write-1-to-clear.
//
// Optional feature macro: PIO_IRQ_DEBOUNCE_EN (per-bit debounce filter in
// front of sync_data; also lengthens the prime window).
// Ports:
//   clock, reset          - sole clock; synchronous active-high reset
//   pin_in                - raw asynchronous pin levels
//   sync_data             - synchronised (optionally debounced) levels
//   rise_en / fall_en     - per-bit edge detect enables
//   irq0_mask / irq1_mask - per-bit enables into irq0 / irq1
//   clr                   - write-1-to-clear pulse for pending
//   pending               - sticky edge-detected bits
//   irq0 / irq1           - registered OR of pending & mask
module pio_irq_detect
    import pio_pkg::*;
#(
    parameter int dataWidth       = PIO_DATA_WIDTH_DEFAULT,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [dataWidth-1:0] pin_in,
    output logic [dataWidth-1:0] sync_data,
    input  logic [dataWidth-1:0] rise_en,
    input  logic [dataWidth-1:0] fall_en,
    input  logic [dataWidth-1:0] irq0_mask,
    input  logic [dataWidth-1:0] irq1_mask,
    input  logic [dataWidth-1:0] clr,
    output logic [dataWidth-1:0] pending,
    output logic                 irq0,
    output logic                 irq1
);

`ifdef PIO_IRQ_DEBOUNCE_EN
    localparam int PRIME_CYCLES = pio_prime_cycles(SYNC_STAGES, DEBOUNCE_CYCLES);
`else
    localparam int PRIME_CYCLES = pio_prime_cycles(SYNC_STAGES, 0);
`endif
    localparam int PW = $clog2(PRIME_CYCLES + 1);

    for (genvar gi = 0; gi < dataWidth; gi++) begin : g_sync
        pio_sync_bit #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_sync_bit (
            .clock   (clock),
            .reset   (reset),
            .pin_in  (pin_in[gi]),
            .sync_out(sync_data[gi])
        );
    end

    logic [dataWidth-1:0] prev_q,    prev_d;
    logic [dataWidth-1:0] pending_q, pending_d;
    logic                 irq0_q,    irq0_d;
    logic                 irq1_q,    irq1_d;
    logic [PW-1:0]        prime_q,   prime_d;
    logic                 prime_done;
    logic [dataWidth-1:0] rise;
    logic [dataWidth-1:0] fall;
    logic [dataWidth-1:0] evt;

    assign prime_done = (prime_q == PW'(PRIME_CYCLES));

    always_comb begin
        // Saturating count: once primed, stays primed until the next reset.
        prime_d = prime_done ? prime_q : prime_q + 1'b1;
        prev_d  = sync_data;

        rise = sync_data & ~prev_q & rise_en;
        fall = ~sync_data & prev_q & fall_en;
        // Pins that were already high at reset would look like rising edges
        // while the chain fills, so events are held off until primed.
        evt  = prime_done ? (rise | fall) : '0;

        // Set wins over a same-cycle clear.
        pending_d = (pending_q & ~clr) | evt;

        // irq follows the registered pending, one cycle behind it.
        irq0_d = |(pending_q & irq0_mask);
        irq1_d = |(pending_q & irq1_mask);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            prev_q    <= '0;
            pending_q <= '0;
            irq0_q    <= 1'b0;
            irq1_q    <= 1'b0;
            prime_q   <= '0;
        end else begin
            prev_q    <= prev_d;
            pending_q <= pending_d;
            irq0_q    <= irq0_d;
            irq1_q    <= irq1_d;
            prime_q   <= prime_d;
        end
    end

    assign pending = pending_q;
    assign irq0    = irq0_q;
    assign irq1    = irq1_q;

endmodule

// File: tb/tb_pio_irq_detect.sv
// Self-checking bench for pio_irq_detect: directed scenarios plus random pin traffic.
// Latency: model tracks pins by edge index, so any pipeline depth is compared exactly.
// Backpressure: n/a.
module tb_pio_irq_detect;

    localparam int S  = 2;
    localparam int D  = 4;
`ifdef PIO_IRQ_DEBOUNCE_EN
    localparam int DB = D;
`else
    localparam int DB = 0;
`endif
    localparam int LAT = S + DB;        // pin change -> event edge offset
    localparam int P   = S + 1 + DB;    // prime window length

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] pin_in, sync_data, rise_en, fall_en, irq0_mask, irq1_mask, clr, pending;
    logic        irq0, irq1;

    int errors = 0;
    int checks = 0;

    pio_irq_detect #(
        .dataWidth      (32),
        .SYNC_STAGES    (S),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .pin_in   (pin_in),
        .sync_data(sync_data),
        .rise_en  (rise_en),
        .fall_en  (fall_en),
        .irq0_mask(irq0_mask),
        .irq1_mask(irq1_mask),
        .clr      (clr),
        .pending  (pending),
        .irq0     (irq0),
        .irq1     (irq1)
    );

    always #5 clock = ~clock;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Every rising clock edge is numbered. The level seen at sync_data after
    // edge m is simply the pin level sampled S-1 edges earlier (zero if that
    // sample predates the latest reset); edges are found by comparing the
    // sync history one and two edges back.
    int          n        = 0;
    int          rst_edge = 0;
    int          k        = 0;
    logic [31:0] pin_hist  [int];
    logic [31:0] sync_hist [int];
    logic [31:0] m_pend = '0;
    logic        m_irq0 = 1'b0;
    logic        m_irq1 = 1'b0;
    logic [31:0] m_filt = '0;
    int          run [32];
    logic [31:0] old_sync, old_prev, ev, r;

    function automatic logic [31:0] raw_at(input int m);
        if (m - S + 1 > rst_edge) return pin_hist[m - S + 1];
        return '0;
    endfunction

    always @(posedge clock) begin
        n++;
        pin_hist[n] = pin_in;
        if (reset) begin
            rst_edge     = n;
            k            = 0;
            sync_hist[n] = '0;
            m_pend       = '0;
            m_irq0       = 1'b0;
            m_irq1       = 1'b0;
            m_filt       = '0;
            for (int b = 0; b < 32; b++) run[b] = 0;
        end else begin
            k++;
            old_sync = sync_hist[n-1];
            old_prev = (n - 1 > rst_edge) ? sync_hist[n-2] : '0;
`ifdef PIO_IRQ_DEBOUNCE_EN
            // A level is accepted once it has disagreed with the filtered
            // level for D consecutive cycles.
            r = raw_at(n - 1);
            for (int b = 0; b < 32; b++) begin
                if (r[b] == m_filt[b]) run[b] = 0;
                else begin
                    run[b]++;
                    if (run[b] == D) begin
                        m_filt[b] = r[b];
                        run[b]    = 0;
                    end
                end
            end
            sync_hist[n] = m_filt;
`else
            r            = raw_at(n);
            sync_hist[n] = r;
`endif
            ev = (k > P) ? ((old_sync & ~old_prev & rise_en) | (~old_sync & old_prev & fall_en)) : '0;
            m_irq0 = |(m_pend & irq0_mask);
            m_irq1 = |(m_pend & irq1_mask);
            m_pend = (m_pend & ~clr) | ev;
        end
    end

    always @(negedge clock) begin
        if (n > 0) begin
            chk_eq("m_sync", sync_data, sync_hist[n]);
            chk_eq("m_pend", pending, m_pend);
            chk_eq("m_irq0", {31'b0, irq0}, {31'b0, m_irq0});
            chk_eq("m_irq1", {31'b0, irq1}, {31'b0, m_irq1});
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_n(input int c);
        repeat (c) @(negedge clock);
    endtask

    task automatic pulse_clr(input logic [31:0] v);
        clr = v;
        @(negedge clock);
        clr = '0;
    endtask

    initial begin
        reset     = 1'b1;
        pin_in    = 32'hFFFF_FFFF;
        rise_en   = 32'hFFFF_FFFF;
        fall_en   = '0;
        irq0_mask = 32'hFFFF_FFFF;
        irq1_mask = '0;
        clr       = '0;

        // Pins high across reset release: no spurious rising edges.
        wait_n(3);
        chk_eq("rst_pend", pending, 32'h0);
        reset = 1'b0;
        repeat (P + 4) begin
            @(negedge clock);
            chk_eq("prime_pend", pending, 32'h0);
            chk_eq("prime_irq0", {31'b0, irq0}, 32'h0);
        end

        // Rising edge on bit 3 into irq0 only; exact latency.
        pin_in = '0; rise_en = '0; irq0_mask = '0;
        wait_n(LAT + 3);
        pulse_clr(32'hFFFF_FFFF);
        rise_en = 32'h8; irq0_mask = 32'h8; irq1_mask = '0;
        wait_n(2);
        pin_in[3] = 1'b1;
        wait_n(LAT);
        chk_eq("tp2_early", pending, 32'h0);
        @(negedge clock);
        chk_eq("tp2_pend", pending, 32'h8);
        chk_eq("tp2_irq0_lag", {31'b0, irq0}, 32'h0);
        @(negedge clock);
        chk_eq("tp2_irq0", {31'b0, irq0}, 32'h1);
        chk_eq("tp2_irq1", {31'b0, irq1}, 32'h0);

        // Falling-only on bit 5; the return rise is ignored.
        pulse_clr(32'h8);
        irq0_mask = '0; rise_en = '0; fall_en = 32'h20;
        pin_in[5] = 1'b1;
        wait_n(LAT + 3);
        chk_eq("tp3_none", pending, 32'h0);
        pin_in[5] = 1'b0;
        wait_n(LAT + 2);
        chk_eq("tp3_fall", pending, 32'h20);
        pin_in[5] = 1'b1;
        wait_n(LAT + 2);
        chk_eq("tp3_rise_ign", pending, 32'h20);

        // Both edges on bit 7; clr colliding with a new event loses.
        pulse_clr(32'hFFFF_FFFF);
        rise_en = 32'h80; fall_en = 32'h80; irq1_mask = 32'h80;
        pin_in[7] = 1'b1;
        wait_n(LAT + 3);
        chk_eq("tp4_set", pending, 32'h80);
        chk_eq("tp4_irq1", {31'b0, irq1}, 32'h1);
        pin_in[7] = 1'b0;
        wait_n(LAT);
        clr = 32'h80;
        @(negedge clock);
        clr = '0;
        chk_eq("tp4_set_wins", pending, 32'h80);
        pulse_clr(32'h80);
        chk_eq("tp4_cleared", pending, 32'h0);
        chk_eq("tp4_irq1_lag", {31'b0, irq1}, 32'h1);
        @(negedge clock);
        chk_eq("tp4_irq1_drop", {31'b0, irq1}, 32'h0);
        pulse_clr(32'h80);   // clear of an already-zero bit
        chk_eq("tp4_clr_zero", pending, 32'h0);

        // Mid-operation reset with pending = F, then re-prime with pins high.
        rise_en = 32'hF; fall_en = '0; irq0_mask = 32'hF; irq1_mask = 32'hF;
        pin_in[3:0] = 4'h0;
        wait_n(LAT + 2);
        pulse_clr(32'hFFFF_FFFF);
        pin_in[3:0] = 4'hF;
        wait_n(LAT + 3);
        chk_eq("tp5_pend", pending, 32'hF);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk_eq("tp5_rst_pend", pending, 32'h0);
        chk_eq("tp5_rst_irq0", {31'b0, irq0}, 32'h0);
        chk_eq("tp5_rst_irq1", {31'b0, irq1}, 32'h0);
        wait_n(P + 3);
        chk_eq("tp5_reprime", pending, 32'h0);

`ifdef PIO_IRQ_DEBOUNCE_EN
        // Short glitch filtered out; a longer level change passes.
        rise_en = 32'h1; fall_en = '0;
        pin_in[0] = 1'b0;
        wait_n(LAT + 3);
        pulse_clr(32'hFFFF_FFFF);
        pin_in[0] = 1'b1;
        wait_n(3);
        pin_in[0] = 1'b0;
        wait_n(LAT + 4);
        chk_eq("db_glitch_sync", {31'b0, sync_data[0]}, 32'h0);
        chk_eq("db_glitch_pend", {31'b0, pending[0]}, 32'h0);
        pin_in[0] = 1'b1;
        wait_n(6);
        pin_in[0] = 1'b0;
        wait_n(S);
        chk_eq("db_level_sync", {31'b0, sync_data[0]}, 32'h1);
        wait_n(2);
        chk_eq("db_level_pend", {31'b0, pending[0]}, 32'h1);
`endif

        // Random traffic against the model.
        for (int c = 0; c < 800; c++) begin
            if (c % 50 == 0) begin
                rise_en   = $urandom;
                fall_en   = $urandom;
                irq0_mask = $urandom & $urandom;
                irq1_mask = $urandom & $urandom;
            end
            pin_in = pin_in ^ ($urandom & $urandom & $urandom);
            clr    = ($urandom_range(0, 3) == 0) ? $urandom : 32'h0;
            reset  = ($urandom_range(0, 199) == 0);
            @(negedge clock);
        end
        reset = 1'b0;
        clr   = '0;
        wait_n(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
